video_timing_gen: RTL and testbench
===================================

VIDEO_TIMING_GEN -- requirements
Module: video_timing_gen

Interface
REQ-001 SHALL have parameter H_ACTIVE, default 848, visible pixels per line.
REQ-002 SHALL have parameter H_FP, default 16, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, default 112, horizontal sync width in pixels.
REQ-004 SHALL have parameter H_BP, default 112, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_ACTIVE, default 480, visible lines per frame.
REQ-006 SHALL have parameter V_FP, default 6, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, default 8, vertical sync width in lines.
REQ-008 SHALL have parameter V_BP, default 23, vertical back porch in lines.
REQ-009 SHALL have parameter HS_POL, default 0, active level of hsync.
REQ-010 SHALL have parameter VS_POL, default 0, active level of vsync.
REQ-011 SHALL have parameter HW, default 11, horizontal counter width.
REQ-012 SHALL have parameter VW, default 10, vertical counter width.
REQ-013 SHALL have port clk  in  1  pixel clock; the block uses one clock only.
REQ-014 SHALL have port rst_n  in  1  asynchronous, active-low reset.
REQ-015 SHALL have port pix_en  in  1  pixel-advance enable.
REQ-016 SHALL have port hsync  out  1  horizontal sync.
REQ-017 SHALL have port vsync  out  1  vertical sync.
REQ-018 SHALL have port disp_en  out  1  active-video flag.
REQ-019 SHALL have port x  out  HW  pixel column.
REQ-020 SHALL have port y  out  VW  pixel row.
REQ-021 SHALL have port line_start  out  1  one-cycle pulse at column 0.
REQ-022 SHALL have port frame_start  out  1  one-cycle pulse at column 0 of row 0.

Function
REQ-023 SHALL define H_TOTAL=H_ACTIVE+H_FP+H_SYNC+H_BP (default 1088) and V_TOTAL=V_ACTIVE+V_FP+V_SYNC+V_BP (default 517).
REQ-024 SHALL keep internal counters cnt_h (0..H_TOTAL-1) and cnt_v (0..V_TOTAL-1), which advance only on edges where pix_en=1.
REQ-025 SHALL wrap cnt_h from H_TOTAL-1 to 0 and increment cnt_v on that same edge; cnt_v SHALL wrap from V_TOTAL-1 to 0 when both counters are at their maximum.
REQ-026 SHALL register every output from the pre-advance counter values on each enabled edge, giving one pix_en cycle of latency.
REQ-027 SHALL hold all outputs, including the one-cycle pulses, whenever pix_en=0; pulses SHALL clear on the next enabled edge.
REQ-028 SHALL drive hsync=HS_POL when cnt_h is in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC), and ~HS_POL otherwise.
REQ-029 SHALL drive vsync=VS_POL when cnt_v is in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC) for the whole line, and ~VS_POL otherwise.
REQ-030 SHALL drive disp_en=1 only when cnt_h<H_ACTIVE and cnt_v<V_ACTIVE.
REQ-031 SHALL drive x=cnt_h and y=cnt_v when disp_en=1; outside active video, x and y SHALL hold their last active values.
REQ-032 SHALL pulse line_start when cnt_h=0, and pulse frame_start when cnt_h=0 and cnt_v=0.
REQ-033 Parameter sets where H_TOTAL>2^HW or V_TOTAL>2^VW are illegal; the behaviour for them is undefined.

Reset
REQ-034 SHALL, while rst_n=0, asynchronously force cnt_h=0, cnt_v=0, hsync=~HS_POL, vsync=~VS_POL, disp_en=0, x=0, y=0, line_start=0 and frame_start=0.
REQ-035 SHALL make the first enabled edge after rst_n rises produce disp_en=1, x=0, y=0, line_start=1 and frame_start=1.
REQ-036 SHALL, on reset asserted mid-frame, abandon the frame and restart from counter position (0,0).

Configuration
REQ-037 SHALL, when macro VTG_LINE_IRQ_EN is defined, add input line_cmp [VW-1:0] and output line_irq, a registered one-cycle pulse produced on the enabled edge where cnt_v=line_cmp and cnt_h=H_ACTIVE; line_irq SHALL reset to 0.
REQ-038 SHALL, when VTG_LINE_IRQ_EN is undefined, omit both ports and all related logic.

Verification
REQ-039 Release reset with pix_en=1 and default parameters -> first edge: frame_start=1, disp_en=1, (x,y)=(0,0); line_start pulses every 1088 edges; frame_start pulses every 562496 edges.
REQ-040 Defaults with HS_POL=0 -> hsync low for exactly 112 edges, first low output after the edge at cnt_h=864; vsync low for 8 full lines starting at row 486.
REQ-041 Toggle pix_en 1,0 alternately -> every output period doubles in clk cycles; frame_start pulse stays high across the disabled cycle and clears on the next enabled edge.
REQ-042 Parameters 4/1/1/1 x 3/1/1/1 -> a 7x6 frame, disp_en high for 4x3 pixels, x/y wrap correctly, and no count exceeds 6 or 5.
REQ-043 Assert rst_n low at (x,y)=(400,300) -> outputs reach their reset values immediately without a clock edge; after release, the frame restarts at (0,0).
REQ-044 With VTG_LINE_IRQ_EN defined and line_cmp=479 -> exactly one line_irq pulse per frame, on the edge at cnt_h=848 of row 479; line_cmp=600 -> no pulse.

Source files
------------

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing generator (sync, active flag, coordinates, line/frame pulses).
// Optional line-compare interrupt is built only when VTG_LINE_IRQ_EN is defined.
module video_timing_gen #(
  parameter int   H_ACTIVE = 848,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 112,
  parameter int   H_BP     = 112,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 6,
  parameter int   V_SYNC   = 8,
  parameter int   V_BP     = 23,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   HW       = 11,
  parameter int   VW       = 10
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          pix_en,
`ifdef VTG_LINE_IRQ_EN
  input  logic [VW-1:0] line_cmp,
  output logic          line_irq,
`endif
  output logic          hsync,
  output logic          vsync,
  output logic          disp_en,
  output logic [HW-1:0] x,
  output logic [VW-1:0] y,
  output logic          line_start,
  output logic          frame_start
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [HW-1:0] H_ACT_END = HW'(H_ACTIVE);
  localparam logic [HW-1:0] H_SYNC_S  = HW'(H_ACTIVE + H_FP);
  localparam logic [HW-1:0] H_SYNC_E  = HW'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [HW-1:0] H_LAST    = HW'(H_TOTAL - 1);
  localparam logic [VW-1:0] V_ACT_END = VW'(V_ACTIVE);
  localparam logic [VW-1:0] V_SYNC_S  = VW'(V_ACTIVE + V_FP);
  localparam logic [VW-1:0] V_SYNC_E  = VW'(V_ACTIVE + V_FP + V_SYNC);
  localparam logic [VW-1:0] V_LAST    = VW'(V_TOTAL - 1);

  logic [HW-1:0] r_cnt_h;
  logic [VW-1:0] r_cnt_v;
  logic          r_hsync;
  logic          r_vsync;
  logic          r_disp_en;
  logic [HW-1:0] r_x;
  logic [VW-1:0] r_y;
  logic          r_line_start;
  logic          r_frame_start;

  logic w_h_last;
  logic w_v_last;
  logic w_hs_act;
  logic w_vs_act;
  logic w_active;

  assign w_h_last = (r_cnt_h == H_LAST);
  assign w_v_last = (r_cnt_v == V_LAST);
  assign w_hs_act = (r_cnt_h >= H_SYNC_S) && (r_cnt_h < H_SYNC_E);
  assign w_vs_act = (r_cnt_v >= V_SYNC_S) && (r_cnt_v < V_SYNC_E);
  assign w_active = (r_cnt_h < H_ACT_END) && (r_cnt_v < V_ACT_END);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt_h <= '0;
      r_cnt_v <= '0;
    end else if (pix_en) begin
      if (w_h_last) begin
        r_cnt_h <= '0;
        r_cnt_v <= w_v_last ? '0 : r_cnt_v + 1'b1;
      end else begin
        r_cnt_h <= r_cnt_h + 1'b1;
      end
    end
  end

  // Outputs are decoded from the pre-advance counters, so they lag by one enabled edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_hsync       <= ~HS_POL;
      r_vsync       <= ~VS_POL;
      r_disp_en     <= 1'b0;
      r_x           <= '0;
      r_y           <= '0;
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else if (pix_en) begin
      r_hsync       <= w_hs_act ? HS_POL : ~HS_POL;
      r_vsync       <= w_vs_act ? VS_POL : ~VS_POL;
      r_disp_en     <= w_active;
      r_line_start  <= (r_cnt_h == '0);
      r_frame_start <= (r_cnt_h == '0) && (r_cnt_v == '0);
      if (w_active) begin
        r_x <= r_cnt_h;
        r_y <= r_cnt_v;
      end
    end
  end

`ifdef VTG_LINE_IRQ_EN
  logic r_line_irq;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_line_irq <= 1'b0;
    end else if (pix_en) begin
      r_line_irq <= (r_cnt_v == line_cmp) && (r_cnt_h == H_ACT_END);
    end
  end

  assign line_irq = r_line_irq;
`endif

  assign hsync       = r_hsync;
  assign vsync       = r_vsync;
  assign disp_en     = r_disp_en;
  assign x           = r_x;
  assign y           = r_y;
  assign line_start  = r_line_start;
  assign frame_start = r_frame_start;

endmodule

// File: tb/tb_video_timing_gen.sv
// tb/tb_video_timing_gen.sv - randomized check of video_timing_gen (default and 7x6 geometry) against a position-arithmetic model.
module tb_video_timing_gen;

  typedef struct {
    logic hs;
    logic vs;
    logic de;
    int   x;
    int   y;
    logic ls;
    logic fs;
    logic irq;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic pen_a, pen_b;

  logic        hs_a, vs_a, de_a, ls_a, fs_a;
  logic [10:0] x_a;
  logic [9:0]  y_a;
  logic        hs_b, vs_b, de_b, ls_b, fs_b;
  logic [2:0]  x_b;
  logic [2:0]  y_b;
`ifdef VTG_LINE_IRQ_EN
  logic [9:0] cmp_a = 10'd1;
  logic [2:0] cmp_b = 3'd2;
  logic       irq_a, irq_b;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  bit started  = 1'b0;
  longint k_a, k_b;

  always #5 clk = ~clk;

  video_timing_gen u_dut_a (
    .clk(clk), .rst_n(rst_n), .pix_en(pen_a),
`ifdef VTG_LINE_IRQ_EN
    .line_cmp(cmp_a), .line_irq(irq_a),
`endif
    .hsync(hs_a), .vsync(vs_a), .disp_en(de_a), .x(x_a), .y(y_a),
    .line_start(ls_a), .frame_start(fs_a)
  );

  video_timing_gen #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(1), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .HS_POL(1'b1), .VS_POL(1'b1), .HW(3), .VW(3)
  ) u_dut_b (
    .clk(clk), .rst_n(rst_n), .pix_en(pen_b),
`ifdef VTG_LINE_IRQ_EN
    .line_cmp(cmp_b), .line_irq(irq_b),
`endif
    .hsync(hs_b), .vsync(vs_b), .disp_en(de_b), .x(x_b), .y(y_b),
    .line_start(ls_b), .frame_start(fs_b)
  );

  // k = enabled edges since reset; outputs reflect raster position k-1.
  function automatic exp_t model(longint k, int ha, int hf, int hsw, int hb,
                                 int va, int vf, int vsw, int vb,
                                 logic hp, logic vp, int cmp);
    exp_t   e;
    int     ht = ha + hf + hsw + hb;
    int     vt = va + vf + vsw + vb;
    longint p;
    int     h, v;
    if (k == 0) begin
      e.hs = ~hp; e.vs = ~vp; e.de = 1'b0; e.x = 0; e.y = 0;
      e.ls = 1'b0; e.fs = 1'b0; e.irq = 1'b0;
      return e;
    end
    p = (k - 1) % (longint'(ht) * vt);
    h = int'(p % ht);
    v = int'(p / ht);
    e.hs  = (h >= ha + hf && h < ha + hf + hsw) ? hp : ~hp;
    e.vs  = (v >= va + vf && v < va + vf + vsw) ? vp : ~vp;
    e.de  = (h < ha) && (v < va);
    if (e.de) begin
      e.x = h; e.y = v;
    end else if (v < va) begin
      e.x = ha - 1; e.y = v;
    end else begin
      e.x = ha - 1; e.y = va - 1;
    end
    e.ls  = (h == 0);
    e.fs  = (h == 0) && (v == 0);
    e.irq = (h == ha) && (v == cmp);
    return e;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      k_a <= 0;
      k_b <= 0;
    end else begin
      if (pen_a) k_a <= k_a + 1;
      if (pen_b) k_b <= k_b + 1;
    end
  end

  always @(negedge clk) begin
    exp_t ea, eb;
    if (started) begin
      ea = model(k_a, 848, 16, 112, 112, 480, 6, 8, 23, 1'b0, 1'b0, 1);
      eb = model(k_b, 4, 1, 1, 1, 3, 1, 1, 1, 1'b1, 1'b1, 2);
      chk("a_hsync", 32'(hs_a), 32'(ea.hs));
      chk("a_vsync", 32'(vs_a), 32'(ea.vs));
      chk("a_disp_en", 32'(de_a), 32'(ea.de));
      chk("a_x", 32'(x_a), ea.x);
      chk("a_y", 32'(y_a), ea.y);
      chk("a_line_start", 32'(ls_a), 32'(ea.ls));
      chk("a_frame_start", 32'(fs_a), 32'(ea.fs));
      chk("b_hsync", 32'(hs_b), 32'(eb.hs));
      chk("b_vsync", 32'(vs_b), 32'(eb.vs));
      chk("b_disp_en", 32'(de_b), 32'(eb.de));
      chk("b_x", 32'(x_b), eb.x);
      chk("b_y", 32'(y_b), eb.y);
      chk("b_line_start", 32'(ls_b), 32'(eb.ls));
      chk("b_frame_start", 32'(fs_b), 32'(eb.fs));
`ifdef VTG_LINE_IRQ_EN
      chk("a_line_irq", 32'(irq_a), 32'(ea.irq));
      chk("b_line_irq", 32'(irq_b), 32'(eb.irq));
`endif
      // Hand-computed anchors for the default geometry and the 7x6 frame.
      if (k_a == 864)  chk("pin_a_hs_before_sync", 32'(hs_a), 1);
      if (k_a == 865)  chk("pin_a_hs_first_low", 32'(hs_a), 0);
      if (k_a == 976)  chk("pin_a_hs_last_low", 32'(hs_a), 0);
      if (k_a == 977)  chk("pin_a_hs_high_again", 32'(hs_a), 1);
      if (k_a == 849)  chk("pin_a_de_off", 32'(de_a), 0);
      if (k_a == 849)  chk("pin_a_x_hold", 32'(x_a), 847);
      if (k_a == 1089) chk("pin_a_line2_ls", 32'(ls_a), 1);
      if (k_a == 1089) chk("pin_a_line2_y", 32'(y_a), 1);
      if (k_a == 1089) chk("pin_a_line2_fs", 32'(fs_a), 0);
      if (k_b == 43)   chk("pin_b_frame2_fs", 32'(fs_b), 1);
      if (k_b == 29)   chk("pin_b_vsync_row4", 32'(vs_b), 1);
      if (k_b == 27)   chk("pin_b_x_hold_row3", 32'(x_b), 3);
      if (k_b == 27)   chk("pin_b_y_hold_row3", 32'(y_b), 2);
    end
  end

  task automatic check_reset_values();
    chk("rst_a_hsync", 32'(hs_a), 1);
    chk("rst_a_vsync", 32'(vs_a), 1);
    chk("rst_a_disp_en", 32'(de_a), 0);
    chk("rst_a_x", 32'(x_a), 0);
    chk("rst_a_y", 32'(y_a), 0);
    chk("rst_a_line_start", 32'(ls_a), 0);
    chk("rst_a_frame_start", 32'(fs_a), 0);
    chk("rst_b_hsync", 32'(hs_b), 0);
    chk("rst_b_vsync", 32'(vs_b), 0);
    chk("rst_b_disp_en", 32'(de_b), 0);
    chk("rst_b_frame_start", 32'(fs_b), 0);
  endtask

  task automatic check_first_edge();
    chk("first_a_frame_start", 32'(fs_a), 1);
    chk("first_a_line_start", 32'(ls_a), 1);
    chk("first_a_disp_en", 32'(de_a), 1);
    chk("first_a_x", 32'(x_a), 0);
    chk("first_a_y", 32'(y_a), 0);
    chk("first_b_frame_start", 32'(fs_b), 1);
    chk("first_b_disp_en", 32'(de_b), 1);
  endtask

  initial begin
    rst_n = 1'b0;
    pen_a = 1'b0;
    pen_b = 1'b0;
    repeat (3) @(negedge clk);
    check_reset_values();
    started = 1'b1;
    rst_n = 1'b1;
    pen_a = 1'b1;
    pen_b = 1'b1;
    @(negedge clk);
    check_first_edge();

    for (int i = 0; i < 3000; i++) begin
      pen_a = ($urandom_range(3) != 0);
      pen_b = ($urandom_range(3) != 0);
      @(negedge clk);
    end

    // Reset asserted between clock edges must take effect without an edge.
    #2 rst_n = 1'b0;
    #1 check_reset_values();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    pen_a = 1'b1;
    pen_b = 1'b1;
    @(negedge clk);
    check_first_edge();

    for (int i = 0; i < 2000; i++) begin
      pen_a = ($urandom_range(3) != 0);
      pen_b = ($urandom_range(1) != 0);
      @(negedge clk);
    end

    for (int i = 0; i < 200; i++) begin
      pen_a = (i % 2 == 0);
      pen_b = (i % 2 == 0);
      @(negedge clk);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
